// File: rtl/shake_pad_packer_if.sv
// Serial message input and lane output handshake of the SHAKE256 pad/pack stage.
// SHAKE_PAD_LEN_CNT_EN adds the msg_bits length counter output.
interface shake_pad_packer_if #(
    parameter int LANE_W = 64,
    parameter int LEN_W  = 32
);
    logic              serial_in;
    logic              in_valid;
    logic              msg_end;
    logic              in_ready;
    logic [LANE_W-1:0] word_out;
    logic              word_valid;
    logic              word_ready;
    logic [4:0]        word_idx;
    logic              block_last;
    logic              msg_done;
`ifdef SHAKE_PAD_LEN_CNT_EN
    logic [LEN_W-1:0]  msg_bits;
`endif

    modport master (
        output serial_in, in_valid, msg_end, word_ready,
        input  in_ready, word_out, word_valid, word_idx, block_last, msg_done
`ifdef SHAKE_PAD_LEN_CNT_EN
        , input msg_bits
`endif
    );

    modport slave (
        input  serial_in, in_valid, msg_end, word_ready,
        output in_ready, word_out, word_valid, word_idx, block_last, msg_done
`ifdef SHAKE_PAD_LEN_CNT_EN
        , output msg_bits
`endif
    );
endinterface

// File: rtl/shake_pad_packer.sv
// Packs a serial message LSB-first into 64-bit lanes and appends SHAKE256 suffix + pad10*1
// at rate 1088. Optional accepted-bit counter enabled by macro SHAKE_PAD_LEN_CNT_EN.
module shake_pad_packer #(
    parameter int LANE_W     = 64,
    parameter int RATE_LANES = 17,
    parameter int LEN_W      = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    shake_pad_packer_if.slave  bus
);
    localparam int RATE_BITS = LANE_W * RATE_LANES;
    localparam int PTR_W     = $clog2(LANE_W) + 1;
    localparam int IDX_W     = 5;
    localparam int ABS_W     = 6;
    localparam int PW        = 12;

    typedef enum logic [1:0] {ABSORB, EMIT, PAD, PADEMIT} state_t;

    state_t            state_reg;
    logic [LANE_W-1:0] lane_reg;
    logic [PTR_W-1:0]  ptr_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic              extra_reg;
    logic              word_valid_reg;
    logic              msg_done_reg;
    logic              in_ready_reg;
    logic [PW-1:0]     pad_pos_reg;
    logic              pad_long_reg;

    logic              bit_acc;
    logic              end_acc;
    logic [PTR_W-1:0]  ptr_inc;
    logic [PW-1:0]     p_abs;
    logic              long_c;
    logic [ABS_W-1:0]  cur_abs;
    logic [ABS_W-1:0]  next_abs;
    logic [ABS_W-1:0]  last_abs;
    logic              idx_wrap;
    logic [IDX_W-1:0]  idx_inc;
    logic [ABS_W-1:0]  mask_abs;
    logic [PW-1:0]     mask_base;
    logic [PW-1:0]     mask_p;
    logic [PW-1:0]     mask_end;
    logic              mask_long;
    logic [LANE_W-1:0] pad_mask;

    assign bit_acc  = in_ready_reg & bus.in_valid;
    assign end_acc  = in_ready_reg & bus.msg_end;
    assign ptr_inc  = ptr_reg + PTR_W'(bit_acc);

    // Message position within the current block; 1088 means a full final lane at index 16.
    assign p_abs    = PW'(idx_reg) * PW'(LANE_W) + PW'(ptr_reg);
    assign long_c   = (p_abs + PW'(6)) > PW'(RATE_BITS);

    // Lane index counted from the start of the block holding the message end (0..33).
    assign cur_abs  = ABS_W'(idx_reg) + (extra_reg ? ABS_W'(RATE_LANES) : ABS_W'(0));
    assign next_abs = cur_abs + ABS_W'(1);
    assign last_abs = pad_long_reg ? ABS_W'(2 * RATE_LANES - 1) : ABS_W'(RATE_LANES - 1);
    assign idx_wrap = (idx_reg == IDX_W'(RATE_LANES - 1));
    assign idx_inc  = idx_wrap ? '0 : idx_reg + IDX_W'(1);

    // PAD completes the current lane; PADEMIT precomputes the lane after the handshake.
    assign mask_abs  = (state_reg == PAD) ? ABS_W'(idx_reg) : next_abs;
    assign mask_p    = (state_reg == PAD) ? p_abs : pad_pos_reg;
    assign mask_long = (state_reg == PAD) ? long_c : pad_long_reg;
    assign mask_base = PW'(mask_abs) * PW'(LANE_W);
    assign mask_end  = mask_long ? PW'(2 * RATE_BITS - 1) : PW'(RATE_BITS - 1);

    genvar gi;
    generate
        for (gi = 0; gi < LANE_W; gi++) begin : g_pad
            logic [PW-1:0] pos;
            assign pos = mask_base + PW'(gi);
            assign pad_mask[gi] = ((pos >= mask_p) && (pos < mask_p + PW'(5))) ||
                                  (pos == mask_end);
        end
    endgenerate

`ifdef SHAKE_PAD_LEN_CNT_EN
    logic [LEN_W-1:0] bits_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bits_reg <= '0;
        end else if (state_reg == PADEMIT && msg_done_reg && bus.word_ready) begin
            bits_reg <= '0;
        end else if (bit_acc) begin
            bits_reg <= bits_reg + LEN_W'(1);
        end
    end

    assign bus.msg_bits = bits_reg;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ABSORB;
            lane_reg       <= '0;
            ptr_reg        <= '0;
            idx_reg        <= '0;
            extra_reg      <= 1'b0;
            word_valid_reg <= 1'b0;
            msg_done_reg   <= 1'b0;
            in_ready_reg   <= 1'b1;
            pad_pos_reg    <= '0;
            pad_long_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ABSORB: begin
                    if (bit_acc) begin
                        lane_reg[ptr_reg[PTR_W-2:0]] <= bus.serial_in;
                        ptr_reg                      <= ptr_inc;
                    end
                    if (end_acc) begin
                        state_reg    <= PAD;
                        in_ready_reg <= 1'b0;
                    end else if (ptr_inc == PTR_W'(LANE_W)) begin
                        state_reg      <= EMIT;
                        in_ready_reg   <= 1'b0;
                        word_valid_reg <= 1'b1;
                    end
                end
                EMIT: begin
                    if (bus.word_ready) begin
                        state_reg      <= ABSORB;
                        in_ready_reg   <= 1'b1;
                        word_valid_reg <= 1'b0;
                        lane_reg       <= '0;
                        ptr_reg        <= '0;
                        idx_reg        <= idx_inc;
                    end
                end
                PAD: begin
                    lane_reg       <= lane_reg | pad_mask;
                    pad_pos_reg    <= p_abs;
                    pad_long_reg   <= long_c;
                    extra_reg      <= 1'b0;
                    msg_done_reg   <= ~long_c & idx_wrap;
                    word_valid_reg <= 1'b1;
                    state_reg      <= PADEMIT;
                end
                PADEMIT: begin
                    if (bus.word_ready) begin
                        if (msg_done_reg) begin
                            state_reg      <= ABSORB;
                            in_ready_reg   <= 1'b1;
                            word_valid_reg <= 1'b0;
                            msg_done_reg   <= 1'b0;
                            lane_reg       <= '0;
                            ptr_reg        <= '0;
                            idx_reg        <= '0;
                        end else begin
                            lane_reg     <= pad_mask;
                            idx_reg      <= idx_inc;
                            msg_done_reg <= (next_abs == last_abs);
                            if (idx_wrap) begin
                                extra_reg <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_reg <= ABSORB;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_reg;
    assign bus.word_out   = lane_reg;
    assign bus.word_valid = word_valid_reg;
    assign bus.word_idx   = idx_reg;
    assign bus.msg_done   = msg_done_reg;
    assign bus.block_last = (idx_reg == IDX_W'(RATE_LANES - 1)) & word_valid_reg;
endmodule

// File: tb/tb_shake_pad_packer.sv
// Randomized bench for shake_pad_packer: a whole-message padding model feeds a scoreboard
// that a single compare process checks on every output handshake.
module tb_shake_pad_packer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shake_pad_packer_if #(.LANE_W(64), .LEN_W(32)) bus ();

    shake_pad_packer #(.LANE_W(64), .RATE_LANES(17), .LEN_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [63:0] word;
        int          idx;
        bit          done;
        int          nbits;
    } exp_t;

    exp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    bit          msg[0:4095];
    bit          stall_mode = 0;
    bit          valid_always = 0;
    bit          ready_always = 0;
    bit          prev_stall = 0;
    logic [63:0] prev_word = '0;
    int          stall_seen = 0;

    function automatic void chk(string name, logic [63:0] actual, logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endfunction

    // Reference: message bits, five ones, zeros up to 1 mod 1088 short of a block, final one.
    function automatic void build_expected(input int n);
        int total;
        total = ((n + 6 + 1087) / 1088) * 1088;
        for (int j = 0; j < total / 64; j++) begin
            exp_t e;
            e.word = '0;
            for (int b = 0; b < 64; b++) begin
                int k;
                k = j * 64 + b;
                if (k < n) e.word[b] = msg[k];
                else       e.word[b] = (k < n + 5) || (k == total - 1);
            end
            e.idx   = j % 17;
            e.done  = (j == total / 64 - 1);
            e.nbits = n;
            exp_q.push_back(e);
        end
    endfunction

    task automatic send_msg(input int n, input bit do_end);
        int i;
        int guard;
        bit ended;
        i = 0;
        guard = 0;
        ended = 0;
        while ((i < n || (do_end && !ended)) && guard < 20000) begin
            @(negedge clk);
            guard++;
            bus.msg_end = 1'b0;
            if (i < n) begin
                bus.in_valid  = valid_always || ($urandom % 4 != 0);
                bus.serial_in = msg[i];
                if (do_end && i == n - 1 && bus.in_valid && ($urandom % 2 == 0))
                    bus.msg_end = 1'b1;
            end else begin
                bus.in_valid  = 1'b0;
                bus.serial_in = 1'b0;
                bus.msg_end   = 1'b1;
            end
            if (bus.in_ready) begin
                if (bus.in_valid) i++;
                if (bus.msg_end) ended = 1;
            end
        end
        if (guard >= 20000) chk("send_timeout", 64'(guard), 64'(0));
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.msg_end   = 1'b0;
        bus.serial_in = 1'b0;
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        chk("drain", 64'(exp_q.size()), 64'(0));
        repeat (2) @(negedge clk);
    endtask

    task automatic run_random(input int n);
        for (int k = 0; k < n; k++) msg[k] = 1'($urandom);
        build_expected(n);
        send_msg(n, 1);
        wait_drain();
    endtask

    initial begin
        forever begin
            @(negedge clk);
            bus.word_ready = stall_mode ? 1'b0 : (ready_always ? 1'b1 : ($urandom % 4 != 0));
        end
    end

    // Compare process: stall stability, in_ready exclusion, and scoreboard on every handshake.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", 64'(bus.word_valid), 64'(1));
                    chk("stall_word", bus.word_out, prev_word);
                end
                if (bus.word_valid) begin
                    chk("in_ready_low", 64'(bus.in_ready), 64'(0));
                    if (stall_mode) stall_seen++;
                end
                if (bus.word_valid && bus.word_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_word", 64'(1), 64'(0));
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("word", bus.word_out, e.word);
                        chk("word_idx", 64'(bus.word_idx), 64'(e.idx));
                        chk("block_last", 64'(bus.block_last), 64'(e.idx == 16));
                        chk("msg_done", 64'(bus.msg_done), 64'(e.done));
`ifdef SHAKE_PAD_LEN_CNT_EN
                        if (e.done) chk("msg_bits", 64'(bus.msg_bits), 64'(e.nbits));
`endif
                    end
                end
                prev_stall = bus.word_valid && !bus.word_ready;
                prev_word  = bus.word_out;
            end
        end
    end

    initial begin
        bus.serial_in  = 1'b0;
        bus.in_valid   = 1'b0;
        bus.msg_end    = 1'b0;
        bus.word_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_word_valid", 64'(bus.word_valid), 64'(0));
        chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
        chk("rst_word_idx", 64'(bus.word_idx), 64'(0));
        chk("rst_word_out", bus.word_out, 64'(0));
        chk("rst_msg_done", 64'(bus.msg_done), 64'(0));
        chk("rst_block_last", 64'(bus.block_last), 64'(0));
`ifdef SHAKE_PAD_LEN_CNT_EN
        chk("rst_msg_bits", 64'(bus.msg_bits), 64'(0));
`endif
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Empty message
        build_expected(0);
        chk("model_empty_l0", exp_q[0].word, 64'h000000000000001F);
        chk("model_empty_l16", exp_q[16].word, 64'h8000000000000000);
        send_msg(0, 1);
        wait_drain();

        // Byte 0xA5, LSB first
        for (int k = 0; k < 8; k++) msg[k] = (k == 0 || k == 2 || k == 5 || k == 7);
        build_expected(8);
        chk("model_a5_l0", exp_q[0].word, 64'h0000000000001FA5);
        send_msg(8, 1);
        wait_drain();

        // 1082 zeros: single block
        for (int k = 0; k < 1083; k++) msg[k] = 1'b0;
        build_expected(1082);
        chk("model_1082_len", 64'(exp_q.size()), 64'(17));
        chk("model_1082_l16", exp_q[16].word, 64'hFC00000000000000);
        send_msg(1082, 1);
        wait_drain();

        // 1083 zeros: extra all-pad block
        build_expected(1083);
        chk("model_1083_len", 64'(exp_q.size()), 64'(34));
        chk("model_1083_l16", exp_q[16].word, 64'hF800000000000000);
        chk("model_1083_l33", exp_q[33].word, 64'h8000000000000000);
        send_msg(1083, 1);
        wait_drain();

        // Long downstream stall while the source keeps in_valid high
        valid_always = 1;
        for (int k = 0; k < 300; k++) msg[k] = 1'($urandom);
        build_expected(300);
        stall_seen = 0;
        fork
            send_msg(300, 1);
            begin
                repeat (30) @(negedge clk);
                stall_mode = 1;
                for (int w = 0; w < 300 && !bus.word_valid; w++) @(negedge clk);
                repeat (20) @(negedge clk);
                stall_mode = 0;
            end
        join
        wait_drain();
        valid_always = 0;
        chk("stall_cycles", 64'(stall_seen >= 20), 64'(1));

        // Boundary and random lengths
        run_random(1);
        run_random(63);
        run_random(64);
        run_random(65);
        run_random(1087);
        run_random(1088);
        run_random(1089);
        run_random(2175);
        run_random(2176);
        for (int r = 0; r < 3; r++) run_random(int'($urandom_range(0, 1500)));

        // Reset mid-block at word_idx=5, ptr=30
        ready_always = 1;
        for (int k = 0; k < 350; k++) msg[k] = 1'($urandom);
        build_expected(350);
        send_msg(350, 0);
        repeat (2) @(negedge clk);
        chk("pre_reset_idx", 64'(bus.word_idx), 64'(5));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_word_valid", 64'(bus.word_valid), 64'(0));
        chk("mid_rst_in_ready", 64'(bus.in_ready), 64'(1));
        chk("mid_rst_word_idx", 64'(bus.word_idx), 64'(0));
        chk("mid_rst_word_out", bus.word_out, 64'(0));
        chk("mid_rst_msg_done", 64'(bus.msg_done), 64'(0));
`ifdef SHAKE_PAD_LEN_CNT_EN
        chk("mid_rst_msg_bits", 64'(bus.msg_bits), 64'(0));
`endif
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ready_always = 0;
        repeat (2) @(negedge clk);
        build_expected(0);
        send_msg(0, 1);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
